// File: rtl/keypad_pkg.sv
// keypad_entry shared types: key codes, matrix map and
// BCD-to-binary helpers.
package keypad_pkg;

  typedef enum logic [3:0] {
    KEY_0     = 4'd0,
    KEY_1     = 4'd1,
    KEY_2     = 4'd2,
    KEY_3     = 4'd3,
    KEY_4     = 4'd4,
    KEY_5     = 4'd5,
    KEY_6     = 4'd6,
    KEY_7     = 4'd7,
    KEY_8     = 4'd8,
    KEY_9     = 4'd9,
    KEY_ENTER = 4'd10,
    KEY_BACK  = 4'd11,
    KEY_CLEAR = 4'd12,
    KEY_IGN   = 4'd13,
    KEY_NONE  = 4'd15
  } key_t;

  localparam logic [12:0] MAX_VAL = 13'd8191;

  // idx = row*4 + col
  function automatic key_t key_map(input logic [3:0] idx);
    key_t k;
    unique case (idx)
      4'd0:  k = KEY_1;
      4'd1:  k = KEY_2;
      4'd2:  k = KEY_3;
      4'd3:  k = KEY_ENTER;
      4'd4:  k = KEY_4;
      4'd5:  k = KEY_5;
      4'd6:  k = KEY_6;
      4'd7:  k = KEY_BACK;
      4'd8:  k = KEY_7;
      4'd9:  k = KEY_8;
      4'd10: k = KEY_9;
      4'd11: k = KEY_CLEAR;
      4'd12: k = KEY_IGN;
      4'd13: k = KEY_0;
      4'd14: k = KEY_IGN;
      4'd15: k = KEY_IGN;
    endcase
    return k;
  endfunction

  // x10 as x8 + x2
  function automatic logic [13:0] bcd_sum(
    input logic [3:0][3:0] d
  );
    logic [13:0] t;
    t = {10'd0, d[3]};
    t = (t << 3) + (t << 1) + {10'd0, d[2]};
    t = (t << 3) + (t << 1) + {10'd0, d[1]};
    t = (t << 3) + (t << 1) + {10'd0, d[0]};
    return t;
  endfunction

  function automatic logic [12:0] sat13(
    input logic [13:0] s
  );
    return (s > {1'b0, MAX_VAL}) ? MAX_VAL : s[12:0];
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Entry/commit output bundle from keypad_entry
// to the display and processor I/O logic.
interface keypad_if;
  logic [12:0] entry_bin;
  logic [2:0]  entry_cnt;
  logic [12:0] value;
  logic        value_valid;
  logic        value_sat;
  logic        digit_ovf;

  modport master (
    output entry_bin,
    output entry_cnt,
    output value,
    output value_valid,
    output value_sat,
    output digit_ovf
  );

  modport slave (
    input entry_bin,
    input entry_cnt,
    input value,
    input value_valid,
    input value_sat,
    input digit_ovf
  );
endinterface

// File: rtl/keypad_scanner.sv
// Row scan, column synchronizer and debounce for a
// 4x4 matrix; emits one key event per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_n_o,
  input  logic [3:0] col_n_i,
  output logic       key_evt_o,
  output key_t       key_code_o
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]    c1_q, c2_q;
  logic [DW-1:0] div_q;
  logic [1:0]    row_q;
  logic [3:0]    row_n_q;
  key_t          scan_q, prev_q, acc_q, code_q;
  logic [SW-1:0] stab_q, stab_d;
  logic          evt_q;

  logic tc;
  logic [3:0] hit;
  key_t row_code, part_d;
  logic accept, fire;

  assign tc  = div_q == DW'(SCAN_DIV - 1);
  assign hit = ~c2_q;

  always_comb begin
    row_code = KEY_NONE;
    for (int c = 3; c >= 0; c--)
      if (hit[c]) row_code = key_map({row_q, 2'(c)});
  end

  // earlier rows keep priority within a scan
  assign part_d = (row_q != 2'd0 && scan_q != KEY_NONE)
                ? scan_q : row_code;

  always_comb begin
    stab_d = SW'(1);
    if (part_d == prev_q)
      stab_d = (stab_q == SW'(DEBOUNCE_SCANS))
             ? stab_q : stab_q + 1'b1;
  end

  assign accept = stab_d == SW'(DEBOUNCE_SCANS);
  assign fire   = accept && part_d != acc_q
               && part_d != KEY_NONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_q    <= 4'hF;
      c2_q    <= 4'hF;
      div_q   <= '0;
      row_q   <= 2'd0;
      row_n_q <= 4'b1110;
      scan_q  <= KEY_NONE;
      prev_q  <= KEY_NONE;
      acc_q   <= KEY_NONE;
      code_q  <= KEY_NONE;
      stab_q  <= '0;
      evt_q   <= 1'b0;
    end else begin
      c1_q  <= col_n_i;
      c2_q  <= c1_q;
      evt_q <= 1'b0;
      if (tc) begin
        div_q   <= '0;
        row_q   <= row_q + 2'd1;
        row_n_q <= {row_n_q[2:0], row_n_q[3]};
        scan_q  <= part_d;
        if (row_q == 2'd3) begin
          prev_q <= part_d;
          stab_q <= stab_d;
          if (accept) acc_q <= part_d;
          evt_q  <= fire;
          code_q <= part_d;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign row_n_o    = row_n_q;
  assign key_evt_o  = evt_q;
  assign key_code_o = code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad digit entry: up to four BCD digits with backspace,
// clear and enter; commits a saturated 13-bit value.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  keypad_if.master   kp
);

  logic key_evt;
  key_t key_code;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_n_o    (row_n),
    .col_n_i    (col_n),
    .key_evt_o  (key_evt),
    .key_code_o (key_code)
  );

  logic [3:0][3:0] d_q;
  logic [2:0]      cnt_q;
  logic [12:0]     val_q;
  logic            vv_q, sat_q, ovf_q;
  logic [13:0]     sum;
  logic            is_dig;

  assign sum    = bcd_sum(d_q);
  assign is_dig = key_code <= KEY_9;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= '0;
      cnt_q <= 3'd0;
      val_q <= '0;
      vv_q  <= 1'b0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      vv_q  <= 1'b0;
      ovf_q <= 1'b0;
      if (key_evt) begin
        unique case (1'b1)
          is_dig: begin
            if (cnt_q == 3'd4) begin
              ovf_q <= 1'b1;
            end else begin
              d_q   <= {d_q[2:0], key_code};
              cnt_q <= cnt_q + 3'd1;
            end
          end
          key_code == KEY_BACK: begin
            if (cnt_q != 3'd0) begin
              d_q   <= {4'd0, d_q[3:1]};
              cnt_q <= cnt_q - 3'd1;
            end
          end
          key_code == KEY_CLEAR: begin
            d_q   <= '0;
            cnt_q <= 3'd0;
          end
          key_code == KEY_ENTER: begin
            val_q <= sat13(sum);
            sat_q <= sum > {1'b0, MAX_VAL};
            vv_q  <= 1'b1;
            d_q   <= '0;
            cnt_q <= 3'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign kp.entry_bin   = sat13(sum);
  assign kp.entry_cnt   = cnt_q;
  assign kp.value       = val_q;
  assign kp.value_valid = vv_q;
  assign kp.value_sat   = sat_q;
  assign kp.digit_ovf   = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: keypad matrix model, directed and
// random key sequences, per-cycle compare against a number model.
`timescale 1ns/1ps
module tb_keypad_entry;

  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] pressed = '0;

  keypad_if kp();

  keypad_entry #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row_n (row_n),
    .col_n (col_n),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // key index -> code (1..9,0 digits; 10 enter, 11 back,
  // 12 clear, 13 ignored, 15 none)
  int km[16] = '{1, 2, 3, 10, 4, 5, 6, 11,
                 7, 8, 9, 12, 13, 0, 13, 13};
  int rows[4] = '{14, 13, 11, 7};

  int m_n, m_num, m_cnt, m_val, m_sat, m_vv, m_ovf;
  int m_acc, pend, pend_code;
  int hist[$];

  function automatic int scan_code(input logic [15:0] p);
    for (int i = 0; i < 16; i++)
      if (p[i]) return km[i];
    return 15;
  endfunction

  task automatic mreset();
    m_n = 0; m_num = 0; m_cnt = 0;
    m_val = 0; m_sat = 0; m_vv = 0; m_ovf = 0;
    m_acc = 15; pend = 0; pend_code = 15;
    hist.delete();
  endtask

  task automatic apply(input int k);
    if (k <= 9) begin
      if (m_cnt < 4) begin
        m_num = m_num * 10 + k;
        m_cnt++;
      end else m_ovf = 1;
    end else if (k == 11) begin
      if (m_cnt > 0) begin
        m_num = m_num / 10;
        m_cnt--;
      end
    end else if (k == 12) begin
      m_num = 0; m_cnt = 0;
    end else if (k == 10) begin
      m_val = (m_num > 8191) ? 8191 : m_num;
      m_sat = (m_num > 8191) ? 1 : 0;
      m_vv = 1;
      m_num = 0; m_cnt = 0;
    end
  endtask

  task automatic scan_step(input int code);
    int run;
    hist.push_back(code);
    while (hist.size() > DB) void'(hist.pop_front());
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != code) break;
      run++;
    end
    if (run == DB && code != m_acc) begin
      m_acc = code;
      if (code != 15) begin
        pend = 1;
        pend_code = code;
      end
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else begin
        m_n++;
        m_vv = 0;
        m_ovf = 0;
        if (pend != 0) begin
          apply(pend_code);
          pend = 0;
        end
        if (m_n % SCAN == 0) scan_step(scan_code(pressed));
      end
    end
  end

  int vv_seen = 0;
  int ovf_seen = 0;

  initial forever begin
    @(negedge clk);
    chk("row_n", int'(row_n), rows[(m_n / SD) % 4]);
    chk("entry_bin", int'(kp.entry_bin),
        (m_num > 8191) ? 8191 : m_num);
    chk("entry_cnt", int'(kp.entry_cnt), m_cnt);
    chk("value", int'(kp.value), m_val);
    chk("value_sat", int'(kp.value_sat), m_sat);
    chk("value_valid", int'(kp.value_valid), m_vv);
    chk("digit_ovf", int'(kp.digit_ovf), m_ovf);
    if (kp.value_valid) vv_seen++;
    if (kp.digit_ovf) ovf_seen++;
  end

  task automatic wait_scans(input int k);
    repeat (k * SCAN) @(negedge clk);
  endtask

  task automatic press(input int idx);
    pressed = 16'(1) << idx;
    wait_scans(5);
    pressed = '0;
    wait_scans(5);
  endtask

  int exp_bin[4] = '{1, 12, 123, 1234};
  int dig_idx[10] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10};

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_row", int'(row_n), 14);
    chk("rst_bin", int'(kp.entry_bin), 0);
    chk("rst_val", int'(kp.value), 0);

    for (int i = 0; i < 4; i++) begin
      press(dig_idx[i + 1]);
      chk("seq_cnt", int'(kp.entry_cnt), i + 1);
      chk("seq_bin", int'(kp.entry_bin), exp_bin[i]);
    end
    vv_seen = 0;
    press(3);
    chk("enter_pulses", vv_seen, 1);
    chk("enter_val", int'(kp.value), 1234);
    chk("enter_sat", int'(kp.value_sat), 0);
    chk("enter_cnt", int'(kp.entry_cnt), 0);

    for (int i = 0; i < 4; i++) press(dig_idx[9]);
    chk("nines_bin", int'(kp.entry_bin), 8191);
    press(3);
    chk("nines_val", int'(kp.value), 8191);
    chk("nines_sat", int'(kp.value_sat), 1);

    for (int i = 5; i <= 8; i++) press(dig_idx[i]);
    ovf_seen = 0;
    press(dig_idx[9]);
    chk("ovf_pulses", ovf_seen, 1);
    chk("ovf_bin", int'(kp.entry_bin), 5678);
    press(7);
    press(7);
    chk("back_bin", int'(kp.entry_bin), 56);
    chk("back_cnt", int'(kp.entry_cnt), 2);
    press(11);
    chk("clr_bin", int'(kp.entry_bin), 0);
    chk("clr_cnt", int'(kp.entry_cnt), 0);

    pressed = 16'(1) << 8;
    wait_scans(20);
    pressed = '0;
    wait_scans(5);
    chk("hold_bin", int'(kp.entry_bin), 7);
    chk("hold_cnt", int'(kp.entry_cnt), 1);

    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? (16'(1) << 9) : '0;
      wait_scans(1);
    end
    pressed = '0;
    wait_scans(5);
    chk("bounce_bin", int'(kp.entry_bin), 7);

    press(11);
    pressed = (16'(1) << 2) | (16'(1) << 6);
    wait_scans(5);
    pressed = '0;
    wait_scans(5);
    chk("multi_bin", int'(kp.entry_bin), 3);
    press(12);
    chk("ign_bin", int'(kp.entry_bin), 3);
    chk("ign_cnt", int'(kp.entry_cnt), 1);

    press(11);
    press(4);
    press(1);
    chk("pre_rst_bin", int'(kp.entry_bin), 42);
    pressed = 16'(1) << 0;
    wait_scans(1);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    pressed = '0;
    #1;
    chk("arst_row", int'(row_n), 14);
    chk("arst_bin", int'(kp.entry_bin), 0);
    chk("arst_cnt", int'(kp.entry_cnt), 0);
    chk("arst_val", int'(kp.value), 0);
    chk("arst_sat", int'(kp.value_sat), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    press(5);
    chk("post_rst_bin", int'(kp.entry_bin), 5);

    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)
        pressed = 16'(1) << $urandom_range(0, 15);
      else if (r < 9)
        pressed = (16'(1) << $urandom_range(0, 15))
                | (16'(1) << $urandom_range(0, 15));
      else
        pressed = '0;
      wait_scans($urandom_range(1, 4));
      pressed = '0;
      wait_scans($urandom_range(0, 3));
    end
    wait_scans(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
